// File: rtl/sync_gen_param.sv
// Parametrised VESA-style video timing generator with pixel clock enable.
// All outputs are registered from the current display/prefetch counters (1 ce-cycle latency).
module sync_gen_param #(
  parameter int CW       = 11,
  parameter int H_VIS    = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_VIS    = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int PREFETCH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  output logic          vga_h_sync,
  output logic          vga_v_sync,
  output logic          inDisplayArea,
  output logic          inPrefetchArea,
  output logic [CW-1:0] counterX,
  output logic [CW-1:0] counterY,
  output logic [CW-1:0] prefetchCounterX,
  output logic [CW-1:0] prefetchCounterY,
  output logic          frameStart,
  output logic          lineStart
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  typedef logic [CW-1:0] coord_t;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_C  = coord_t'(H_VIS);
  localparam coord_t V_VIS_C  = coord_t'(V_VIS);
  localparam coord_t H_SS     = coord_t'(H_VIS + H_FP);
  localparam coord_t H_SE     = coord_t'(H_VIS + H_FP + H_SYNC);
  localparam coord_t V_SS     = coord_t'(V_VIS + V_FP);
  localparam coord_t V_SE     = coord_t'(V_VIS + V_FP + V_SYNC);
  localparam coord_t P_INIT   = coord_t'(PREFETCH);
  localparam coord_t ONE      = coord_t'(1);

  coord_t cx, cy, px, py;

  // Display and prefetch counter pairs; the prefetch pair is simply the display
  // pair started PREFETCH pixels ahead, so no modulo arithmetic is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx <= '0;
      cy <= '0;
      px <= P_INIT;
      py <= '0;
    end else if (ce) begin
      // NOTE: non-blocking so the output block below sees the pre-increment values.
      if (cx == H_LAST) begin
        cx <= '0;
        cy <= (cy == V_LAST) ? '0 : cy + ONE;
      end else begin
        cx <= cx + ONE;
      end

      if (px == H_LAST) begin
        px <= '0;
        py <= (py == V_LAST) ? '0 : py + ONE;
      end else begin
        px <= px + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_h_sync       <= ~H_POL;
      vga_v_sync       <= ~V_POL;
      inDisplayArea    <= 1'b0;
      inPrefetchArea   <= 1'b0;
      counterX         <= '0;
      counterY         <= '0;
      prefetchCounterX <= '0;
      prefetchCounterY <= '0;
      frameStart       <= 1'b0;
      lineStart        <= 1'b0;
    end else if (ce) begin
      vga_h_sync       <= (cx >= H_SS && cx < H_SE) ? H_POL : ~H_POL;
      inDisplayArea    <= (cx < H_VIS_C) && (cy < V_VIS_C);
      inPrefetchArea   <= (px < H_VIS_C) && (py < V_VIS_C);
      counterX         <= cx;
      counterY         <= cy;
      prefetchCounterX <= px;
      prefetchCounterY <= py;
      lineStart        <= (cx == '0);
      frameStart       <= (cx == '0) && (cy == '0);
      // vsync only moves on the hsync leading edge so both edges line up.
      if (cx == H_SS)
        vga_v_sync <= (cy >= V_SS && cy < V_SE) ? V_POL : ~V_POL;
    end
  end

endmodule

// File: tb/tb_sync_gen_param.sv
// Self-checking bench for sync_gen_param using a small 16x8 timing and a
// frame-position reference model, with one positive- and one negative-polarity instance.
module tb_sync_gen_param;

  localparam int HT = 16;
  localparam int VT = 8;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        disp;
    logic        pre;
    logic [10:0] cx;
    logic [10:0] cy;
    logic [10:0] px;
    logic [10:0] py;
    logic        fs;
    logic        ls;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  logic hs_p, vs_p, disp_p, pre_p, fs_p, ls_p;
  logic [10:0] cx_p, cy_p, px_p, py_p;
  logic hs_n, vs_n, disp_n, pre_n, fs_n, ls_n;
  logic [10:0] cx_n, cy_n, px_n, py_n;

  out_t obs_p, obs_n, snap;
  assign obs_p = {hs_p, vs_p, disp_p, pre_p, cx_p, cy_p, px_p, py_p, fs_p, ls_p};
  assign obs_n = {hs_n, vs_n, disp_n, pre_n, cx_n, cy_n, px_n, py_n, fs_n, ls_n};

  int checks = 0;
  int passed = 0;
  int k = 0;  // ce edges accepted since the last reset release

  always #5 clk = ~clk;

  sync_gen_param #(
    .CW(11), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .PREFETCH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .vga_h_sync(hs_p), .vga_v_sync(vs_p),
    .inDisplayArea(disp_p), .inPrefetchArea(pre_p),
    .counterX(cx_p), .counterY(cy_p),
    .prefetchCounterX(px_p), .prefetchCounterY(py_p),
    .frameStart(fs_p), .lineStart(ls_p)
  );

  sync_gen_param #(
    .CW(11), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .PREFETCH(2)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .vga_h_sync(hs_n), .vga_v_sync(vs_n),
    .inDisplayArea(disp_n), .inPrefetchArea(pre_n),
    .counterX(cx_n), .counterY(cy_n),
    .prefetchCounterX(px_n), .prefetchCounterY(py_n),
    .frameStart(fs_n), .lineStart(ls_n)
  );

  // Expected outputs after kk accepted ce edges: edge kk reports pixel number kk-1
  // of an endless raster, so everything follows from that pixel's frame position.
  function automatic out_t model(int kk, bit hp, bit vp);
    out_t o;
    int n, x, line, y, al, pn;
    o = '0;
    o.hs = ~hp;
    o.vs = ~vp;
    if (kk == 0) return o;
    n    = kk - 1;
    x    = n % HT;
    line = n / HT;
    y    = line % VT;
    o.hs   = (x >= 10 && x < 13) ? hp : ~hp;
    al     = (x >= 10) ? line : line - 1;   // last line whose hsync edge has passed
    o.vs   = (al >= 0 && (al % VT) >= 5 && (al % VT) < 7) ? vp : ~vp;
    o.disp = (x < 8) && (y < 4);
    o.cx   = 11'(x);
    o.cy   = 11'(y);
    pn     = n + 2;
    o.px   = 11'(pn % HT);
    o.py   = 11'((pn / HT) % VT);
    o.pre  = (pn % HT < 8) && ((pn / HT) % VT < 4);
    o.ls   = (x == 0);
    o.fs   = (x == 0) && (y == 0);
    return o;
  endfunction

  // One clock: drive ce, take the edge, come back to the falling edge for sampling.
  task automatic tick(input bit c);
    ce = c;
    @(posedge clk);
    if (c && rst_n) k++;
    @(negedge clk);
  endtask

  task automatic run_until(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b1);
      if (cx_p == 11'(x) && cy_p == 11'(y)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick(1'b1);
    k = 0;
    checks++;
    if (obs_p !== model(0, 1'b1, 1'b1)) $display("FAIL reset_pos: got %h expected %h", obs_p, model(0, 1'b1, 1'b1));
    else passed++;
    checks++;
    if (obs_n !== model(0, 1'b0, 1'b0)) $display("FAIL reset_neg: got %h expected %h", obs_n, model(0, 1'b0, 1'b0));
    else passed++;
    rst_n = 1'b1;
    tick(1'b1);
    checks++;
    if ({disp_p, fs_p, ls_p, cx_p, cy_p} !== {3'b111, 11'd0, 11'd0})
      $display("FAIL first_edge: got disp=%b fs=%b ls=%b x=%0d y=%0d expected 1 1 1 0 0", disp_p, fs_p, ls_p, cx_p, cy_p);
    else passed++;
    checks++;
    if (obs_p !== model(k, 1'b1, 1'b1)) $display("FAIL first_edge_model: got %h expected %h", obs_p, model(k, 1'b1, 1'b1));
    else passed++;
  endtask

  task automatic test_frame;
    int n_fs = 0, n_vs = 0, n_hs = 0, n_disp = 0, bad = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1'b1);
      n_fs   += int'(fs_p);
      n_vs   += int'(vs_p);
      n_hs   += int'(hs_p);
      n_disp += int'(disp_p);
      checks++;
      if (obs_p !== model(k, 1'b1, 1'b1)) begin
        if (bad < 5) $display("FAIL frame_pos k=%0d: got %h expected %h", k, obs_p, model(k, 1'b1, 1'b1));
        bad++;
      end else passed++;
    end
    checks++;
    if (n_fs !== 2) $display("FAIL frame_start_count: got %0d expected 2", n_fs);
    else passed++;
    checks++;
    if (n_vs !== 64) $display("FAIL vsync_high_count: got %0d expected 64", n_vs);
    else passed++;
    checks++;
    if (n_hs !== 48) $display("FAIL hsync_high_count: got %0d expected 48", n_hs);
    else passed++;
    checks++;
    if (n_disp !== 64) $display("FAIL display_count: got %0d expected 64", n_disp);
    else passed++;
  endtask

  task automatic test_prefetch;
    bit ok;
    run_until(14, 7, ok);
    checks++;
    if (!ok || px_p !== 11'd0 || py_p !== 11'd0)
      $display("FAIL prefetch_wrap: reached=%b got px=%0d py=%0d expected 0 0", ok, px_p, py_p);
    else passed++;
    run_until(7, 3, ok);
    checks++;
    if (!ok || {px_p, py_p, pre_p, disp_p} !== {11'd9, 11'd3, 1'b0, 1'b1})
      $display("FAIL prefetch_last_pixel: reached=%b got px=%0d py=%0d pre=%b disp=%b expected 9 3 0 1",
               ok, px_p, py_p, pre_p, disp_p);
    else passed++;
  endtask

  task automatic test_ce_hold;
    bit ok;
    int bad = 0;
    run_until(4, 1, ok);
    checks++;
    if (!ok) $display("FAIL ce_hold_reach: got timeout expected x=4 y=1");
    else passed++;
    snap = obs_p;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      if (obs_p !== snap) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL ce_hold: got %0d changed cycles expected 0", bad);
    else passed++;
    tick(1'b1);
    checks++;
    if (cx_p !== 11'd5 || obs_p !== model(k, 1'b1, 1'b1))
      $display("FAIL ce_resume: got x=%0d obs %h expected x=5 obs %h", cx_p, obs_p, model(k, 1'b1, 1'b1));
    else passed++;
  endtask

  task automatic test_random_ce;
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)));
      checks++;
      if (obs_p !== model(k, 1'b1, 1'b1) || obs_n !== model(k, 1'b0, 1'b0)) begin
        if (bad < 5) $display("FAIL random_ce k=%0d: got %h/%h expected %h/%h", k, obs_p, obs_n,
                              model(k, 1'b1, 1'b1), model(k, 1'b0, 1'b0));
        bad++;
      end else passed++;
    end
  endtask

  task automatic test_polarity_reset;
    bit ok;
    int bad = 0;
    run_until(11, 5, ok);
    checks++;
    if (!ok || {hs_n, vs_n, hs_p, vs_p} !== 4'b0011)
      $display("FAIL polarity_active: reached=%b got n=%b%b p=%b%b expected n=00 p=11", ok, hs_n, vs_n, hs_p, vs_p);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({hs_n, vs_n, hs_p, vs_p} !== 4'b1100 || cx_p !== 11'd0 || cy_p !== 11'd0)
      $display("FAIL async_reset: got n=%b%b p=%b%b x=%0d y=%0d expected n=11 p=00 x=0 y=0",
               hs_n, vs_n, hs_p, vs_p, cx_p, cy_p);
    else passed++;
    @(negedge clk);
    tick(1'b1);
    k = 0;
    rst_n = 1'b1;
    tick(1'b1);
    checks++;
    if ({cx_p, cy_p, fs_p} !== {11'd0, 11'd0, 1'b1})
      $display("FAIL restart: got x=%0d y=%0d fs=%b expected 0 0 1", cx_p, cy_p, fs_p);
    else passed++;
    for (int i = 0; i < 140; i++) begin
      tick(1'b1);
      checks++;
      if (obs_n !== model(k, 1'b0, 1'b0)) begin
        if (bad < 5) $display("FAIL neg_polarity k=%0d: got %h expected %h", k, obs_n, model(k, 1'b0, 1'b0));
        bad++;
      end else passed++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame();
    test_prefetch();
    test_ce_hold();
    test_random_ce();
    test_polarity_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
